alu_muldiv: RTL and testbench

//  Parametrised, registered successor to the MIPS single-cycle ALU. Keeps the 3-bit ALU codes,

---
 rtl/alu_pkg.sv | 28 ++
 rtl/muldiv_iter.sv | 92 +++++++++
 rtl/alu_muldiv.sv | 165 ++++++++++++++++
 tb/tb_alu_muldiv.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the alu_muldiv EX-stage ALU.
package alu_pkg;

    localparam int ALU_CTRL_W = 4;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_SUB   = 4'b0110,
        ALU_SLT   = 4'b0111,
        ALU_MULT  = 4'b1000,
        ALU_MULTU = 4'b1001,
        ALU_DIV   = 4'b1010,
        ALU_DIVU  = 4'b1011,
        ALU_MFHI  = 4'b1100,
        ALU_MFLO  = 4'b1101,
        ALU_XOR   = 4'b1110,
        ALU_NOR   = 4'b1111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } alu_state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes.
// done is asserted during the last iteration; hi/lo then carry the sign-corrected result.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic               active_q;
    logic               div_q;
    logic               neg_res_q;
    logic               neg_rem_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opb_q;

    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH:0]     add_s;
    logic [WIDTH:0]     trial_s;
    logic [2*WIDTH-1:0] mul_next_s;
    logic [2*WIDTH-1:0] div_next_s;
    logic [2*WIDTH-1:0] next_s;
    logic [2*WIDTH-1:0] neg_full_s;

    assign mag_a_s = (is_signed && a[WIDTH-1]) ? ({WIDTH{1'b0}} - a) : a;
    assign mag_b_s = (is_signed && b[WIDTH-1]) ? ({WIDTH{1'b0}} - b) : b;

    // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
    assign add_s      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    assign mul_next_s = acc_q[0] ? {add_s, acc_q[WIDTH-1:1]}
                                 : {1'b0, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1:1]};
    assign trial_s    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opb_q};
    assign div_next_s = trial_s[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                       : {trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    assign next_s     = div_q ? div_next_s : mul_next_s;
    assign neg_full_s = {(2*WIDTH){1'b0}} - next_s;
    assign done       = active_q && (cnt_q == LAST);

    // Sign fix-up applied to the outcome of the current (final) iteration
    always_comb begin
        hi = next_s[2*WIDTH-1:WIDTH];
        lo = next_s[WIDTH-1:0];
        if (div_q) begin
            lo = neg_res_q ? ({WIDTH{1'b0}} - next_s[WIDTH-1:0]) : next_s[WIDTH-1:0];
            hi = neg_rem_q ? ({WIDTH{1'b0}} - next_s[2*WIDTH-1:WIDTH]) : next_s[2*WIDTH-1:WIDTH];
        end else begin
            {hi, lo} = neg_res_q ? neg_full_s : next_s;
        end
    end

    // Operand capture on start, then one iteration per cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q  <= 1'b0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
            acc_q     <= {(2*WIDTH){1'b0}};
            opb_q     <= {WIDTH{1'b0}};
        end else if (start) begin
            active_q  <= 1'b1;
            div_q     <= is_div;
            neg_res_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_q <= is_signed && a[WIDTH-1];
            cnt_q     <= {CNT_W{1'b0}};
            acc_q     <= {{WIDTH{1'b0}}, mag_a_s};
            opb_q     <= mag_b_s;
        end else if (active_q) begin
            acc_q <= next_s;
            if (done) begin
                active_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Registered MIPS-style ALU with iterative mul/div, HI/LO and valid/ready handshake.
// Optional: define ALU_OVERFLOW_EN to add the registered signed-overflow output.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ALU_CTRL_W-1:0] alu_control,
    input  logic [WIDTH-1:0]      src1,
    input  logic [WIDTH-1:0]      src2,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      result,
    output logic                  zero,
    output logic                  busy,
    output logic [WIDTH-1:0]      hi,
    output logic [WIDTH-1:0]      lo
`ifdef ALU_OVERFLOW_EN
    ,
    output logic                  overflow
`endif
);

    alu_state_t       state_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    alu_op_t          op_s;
    logic             accept_s;
    logic             is_mul_s;
    logic             is_div_s;
    logic             div0_s;
    logic             start_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;
    logic [WIDTH-1:0] simple_s;
    logic             md_done_s;
    logic [WIDTH-1:0] md_hi_s;
    logic [WIDTH-1:0] md_lo_s;

    assign op_s     = alu_op_t'(alu_control);
    assign accept_s = in_valid && (state_q == IDLE);
    assign is_mul_s = (op_s == ALU_MULT) || (op_s == ALU_MULTU);
    assign is_div_s = (op_s == ALU_DIV) || (op_s == ALU_DIVU);
    assign div0_s   = is_div_s && (src2 == {WIDTH{1'b0}});
    assign start_s  = accept_s && (is_mul_s || (is_div_s && !div0_s));
    assign sum_s    = src1 + src2;
    assign diff_s   = src1 - src2;

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk       (clk),
        .reset     (reset),
        .start     (start_s),
        .is_div    (is_div_s),
        .is_signed ((op_s == ALU_MULT) || (op_s == ALU_DIV)),
        .a         (src1),
        .b         (src2),
        .done      (md_done_s),
        .hi        (md_hi_s),
        .lo        (md_lo_s)
    );

    // Single-cycle result; a DIV/DIVU only reaches here when dividing by zero
    always_comb begin
        simple_s = {WIDTH{1'b0}};
        case (op_s)
            ALU_AND:             simple_s = src1 & src2;
            ALU_OR:              simple_s = src1 | src2;
            ALU_ADD:             simple_s = sum_s;
            ALU_SUB:             simple_s = diff_s;
            ALU_SLT:             simple_s = {{(WIDTH-1){1'b0}}, ($signed(src1) < $signed(src2))};
            ALU_XOR:             simple_s = src1 ^ src2;
            ALU_NOR:             simple_s = ~(src1 | src2);
            ALU_MFHI:            simple_s = hi_q;
            ALU_MFLO:            simple_s = lo_q;
            ALU_DIV, ALU_DIVU:   simple_s = {WIDTH{1'b1}};
            default:             simple_s = {WIDTH{1'b0}};
        endcase
    end

    // Control FSM with registered result, zero and HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            zero_q      <= 1'b1;
            hi_q        <= {WIDTH{1'b0}};
            lo_q        <= {WIDTH{1'b0}};
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_s) begin
                        state_q <= is_mul_s ? MUL : DIV;
                    end else if (accept_s) begin
                        out_valid_q <= 1'b1;
                        result_q    <= simple_s;
                        zero_q      <= (simple_s == {WIDTH{1'b0}});
                        if (div0_s) begin
                            hi_q <= src1;
                            lo_q <= {WIDTH{1'b1}};
                        end
                    end
                end
                MUL, DIV: begin
                    if (md_done_s) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b1;
                        hi_q        <= md_hi_s;
                        lo_q        <= md_lo_s;
                        result_q    <= md_lo_s;
                        zero_q      <= (md_lo_s == {WIDTH{1'b0}});
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ALU_OVERFLOW_EN
    logic ovf_s;
    logic ovf_q;

    assign overflow = ovf_q;

    // Signed overflow: operands agree in sign (ADD) or differ (SUB) and the result sign flips
    always_comb begin
        ovf_s = 1'b0;
        if (op_s == ALU_ADD) begin
            ovf_s = (src1[WIDTH-1] == src2[WIDTH-1]) && (sum_s[WIDTH-1] != src1[WIDTH-1]);
        end else if (op_s == ALU_SUB) begin
            ovf_s = (src1[WIDTH-1] != src2[WIDTH-1]) && (diff_s[WIDTH-1] != src1[WIDTH-1]);
        end else begin
            ovf_s = 1'b0;
        end
    end

    // Overflow flag updates alongside result
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (state_q == IDLE && accept_s && !start_s) begin
            ovf_q <= ovf_s;
        end else if (state_q != IDLE && md_done_s) begin
            ovf_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv (WIDTH=32): driver queues expectations, monitor checks on out_valid.
module tb_alu_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_control;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef ALU_OVERFLOW_EN
    logic        overflow;
`endif

    alu_muldiv #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .src1        (src1),
        .src2        (src2),
        .out_valid   (out_valid),
        .result      (result),
        .zero        (zero),
        .busy        (busy),
        .hi          (hi),
        .lo          (lo)
`ifdef ALU_OVERFLOW_EN
        ,
        .overflow    (overflow)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       nm;
        logic [31:0] res;
        logic        chl;
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    // Issue one op, holding in_valid until in_ready; expected values are pushed on accept
    task automatic issue(input string nm, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic chl,
                         input logic [31:0] eh, input logic [31:0] el, input int lat,
                         input logic eo);
        exp_t e;
        int   g;
        alu_control = op;
        src1        = a;
        src2        = b;
        in_valid    = 1'b1;
        g = 0;
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            chk({nm, "_accept_timeout"}, {31'd0, in_ready}, 32'd1);
        end else begin
            e.nm  = nm;
            e.res = er;
            e.chl = chl;
            e.hi  = eh;
            e.lo  = el;
            e.due = cyc + lat;
            e.ovf = eo;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int g;
        g = 0;
        while (sb.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0) chk({nm, "_drain_timeout"}, sb.size(), 32'd0);
    endtask

    // Monitor: every out_valid pulse must match the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk({e.nm, "_cycle"}, cyc, e.due);
                chk({e.nm, "_result"}, result, e.res);
                chk({e.nm, "_zero"}, {31'd0, zero}, {31'd0, (e.res == 32'd0)});
                if (e.chl) begin
                    chk({e.nm, "_hi"}, hi, e.hi);
                    chk({e.nm, "_lo"}, lo, e.lo);
                end
`ifdef ALU_OVERFLOW_EN
                chk({e.nm, "_ovf"}, {31'd0, overflow}, {31'd0, e.ovf});
`endif
            end
        end
    end

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        alu_control = 4'd0;
        src1        = 32'd0;
        src2        = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        // Simple ops, back to back at one per cycle
        issue("add",    4'b0010, 32'd17, 32'd10, 32'd27, 1'b0, 32'd0, 32'd0, 1, 1'b0);
        issue("sub",    4'b0110, 32'd17, 32'd10, 32'd7,  1'b0, 32'd0, 32'd0, 1, 1'b0);
        issue("and",    4'b0000, 32'd17, 32'd10, 32'd0,  1'b0, 32'd0, 32'd0, 1, 1'b0);
        issue("or",     4'b0001, 32'd17, 32'd10, 32'd27, 1'b0, 32'd0, 32'd0, 1, 1'b0);
        issue("slt_gt", 4'b0111, 32'd17, 32'd10, 32'd0,  1'b0, 32'd0, 32'd0, 1, 1'b0);
        issue("slt_eq", 4'b0111, 32'd10, 32'd10, 32'd0,  1'b0, 32'd0, 32'd0, 1, 1'b0);
        issue("slt_neg",4'b0111, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b0, 32'd0, 32'd0, 1, 1'b0);
        issue("xor",    4'b1110, 32'd17, 32'd10, 32'd27, 1'b0, 32'd0, 32'd0, 1, 1'b0);
        issue("nor",    4'b1111, 32'd0,  32'd0,  32'hFFFFFFFF, 1'b0, 32'd0, 32'd0, 1, 1'b0);
        issue("ill0101",4'b0101, 32'd17, 32'd10, 32'd0,  1'b0, 32'd0, 32'd0, 1, 1'b0);
        issue("ill0100",4'b0100, 32'd17, 32'd10, 32'd0,  1'b0, 32'd0, 32'd0, 1, 1'b0);
        issue("add_wrap",4'b0010, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 32'd0, 32'd0, 1, 1'b0);
        issue("add_ovf",4'b0010, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 32'd0, 32'd0, 1, 1'b1);
        issue("sub_m1", 4'b0110, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0, 32'd0, 32'd0, 1, 1'b0);
        drain("simple");

        // Multiply / divide; each follow-on op is held until the previous result cycle
        issue("mult",   4'b1000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 1'b0);
        chk("mult_busy", {31'd0, busy}, 32'd1);
        chk("mult_in_ready", {31'd0, in_ready}, 32'd0);
        issue("multu",  4'b1001, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b1, 32'd1, 32'hFFFFFFFE, 33, 1'b0);
        issue("mfhi",   4'b1100, 32'd0, 32'd0, 32'd1, 1'b0, 32'd0, 32'd0, 1, 1'b0);
        issue("div",    4'b1010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0);
        issue("divu0",  4'b1011, 32'd7, 32'd0, 32'hFFFFFFFF, 1'b1, 32'd7, 32'hFFFFFFFF, 1, 1'b0);
        issue("div_min",4'b1010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 32'd0, 32'h80000000, 33, 1'b0);
        issue("mult67", 4'b1000, 32'd6, 32'd7, 32'd42, 1'b1, 32'd0, 32'd42, 33, 1'b0);
        issue("mflo",   4'b1101, 32'd0, 32'd0, 32'd42, 1'b0, 32'd0, 32'd0, 1, 1'b0);
        issue("divu",   4'b1011, 32'd100, 32'd7, 32'd14, 1'b1, 32'd2, 32'd14, 33, 1'b0);
        issue("add_held",4'b0010, 32'd1, 32'd2, 32'd3, 1'b0, 32'd0, 32'd0, 1, 1'b0);
        drain("muldiv");

        // Reset in cycle 10 of a DIV: aborted, no out_valid, HI/LO cleared
        alu_control = 4'b1010;
        src1        = 32'd100;
        src2        = 32'd3;
        in_valid    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        issue("post_abort", 4'b0010, 32'd5, 32'd6, 32'd11, 1'b0, 32'd0, 32'd0, 1, 1'b0);
        drain("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
